// File: rtl/svn_seg_pkg.sv
// Shared constants for the multiplexed seven-segment driver: segment bit positions
// and the active-low glyph table (dp bit held off in every glyph).
package svn_seg_pkg;

    localparam int SEG_A  = 7;
    localparam int SEG_B  = 6;
    localparam int SEG_C  = 5;
    localparam int SEG_D  = 4;
    localparam int SEG_E  = 3;
    localparam int SEG_F  = 2;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [7:0] GLYPH_0 = 8'b0000001_1;
    localparam logic [7:0] GLYPH_1 = 8'b1001111_1;
    localparam logic [7:0] GLYPH_2 = 8'b0010010_1;
    localparam logic [7:0] GLYPH_3 = 8'b0000110_1;
    localparam logic [7:0] GLYPH_4 = 8'b1001100_1;
    localparam logic [7:0] GLYPH_5 = 8'b0100100_1;
    localparam logic [7:0] GLYPH_6 = 8'b0100000_1;
    localparam logic [7:0] GLYPH_7 = 8'b0001111_1;
    localparam logic [7:0] GLYPH_8 = 8'b0000000_1;
    localparam logic [7:0] GLYPH_9 = 8'b0000100_1;
    localparam logic [7:0] GLYPH_A = 8'b0001000_1;
    localparam logic [7:0] GLYPH_B = 8'b1100000_1;
    localparam logic [7:0] GLYPH_C = 8'b0110001_1;
    localparam logic [7:0] GLYPH_D = 8'b1000010_1;
    localparam logic [7:0] GLYPH_E = 8'b0110000_1;
    localparam logic [7:0] GLYPH_F = 8'b0111000_1;

endpackage

// File: rtl/svn_seg_dec.sv
// Combinational 4-bit code to 7-segment glyph {a..g}, 0 = lit.
// Codes 10..15 go dark when hex glyphs are disabled.
module svn_seg_dec
    import svn_seg_pkg::*;
(
    input  logic [3:0] code_i,
    input  logic       hex_en_i,
    output logic [6:0] glyph_o
);

    always_comb begin
        glyph_o = SEG_BLANK[SEG_A:SEG_G];
        case (code_i)
            4'h0: glyph_o = GLYPH_0[SEG_A:SEG_G];
            4'h1: glyph_o = GLYPH_1[SEG_A:SEG_G];
            4'h2: glyph_o = GLYPH_2[SEG_A:SEG_G];
            4'h3: glyph_o = GLYPH_3[SEG_A:SEG_G];
            4'h4: glyph_o = GLYPH_4[SEG_A:SEG_G];
            4'h5: glyph_o = GLYPH_5[SEG_A:SEG_G];
            4'h6: glyph_o = GLYPH_6[SEG_A:SEG_G];
            4'h7: glyph_o = GLYPH_7[SEG_A:SEG_G];
            4'h8: glyph_o = GLYPH_8[SEG_A:SEG_G];
            4'h9: glyph_o = GLYPH_9[SEG_A:SEG_G];
            4'hA: if (hex_en_i) glyph_o = GLYPH_A[SEG_A:SEG_G];
            4'hB: if (hex_en_i) glyph_o = GLYPH_B[SEG_A:SEG_G];
            4'hC: if (hex_en_i) glyph_o = GLYPH_C[SEG_A:SEG_G];
            4'hD: if (hex_en_i) glyph_o = GLYPH_D[SEG_A:SEG_G];
            4'hE: if (hex_en_i) glyph_o = GLYPH_E[SEG_A:SEG_G];
            4'hF: if (hex_en_i) glyph_o = GLYPH_F[SEG_A:SEG_G];
            default: glyph_o = SEG_BLANK[SEG_A:SEG_G];
        endcase
    end

endmodule

// File: rtl/svn_seg_mux.sv
// Time-multiplexed NUM_DIGITS seven-segment driver with tear-free shadow data,
// leading-zero blanking and a per-slot dead time on the digit enables.
module svn_seg_mux
    import svn_seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int CLK_DIV       = 50000,
    parameter int BLANK_CYCLES  = 2,
    parameter int HEX_EN        = 1,
    parameter int AN_ACTIVE_LOW = 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [4*NUM_DIGITS-1:0] DATA,
    input  logic [NUM_DIGITS-1:0]   DP,
    input  logic                    LOAD,
    input  logic                    LZ_BLANK,
    output logic [7:0]              SEG,
    output logic [NUM_DIGITS-1:0]   AN,
    output logic                    FRAME
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int D_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW    = 4 * NUM_DIGITS;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [D_W-1:0]   D_LAST   = D_W'(NUM_DIGITS - 1);
    localparam logic             AN_ON    = (AN_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [D_W-1:0]        d_q, d_d;
    logic [DW-1:0]         sh_q, sh_d, pd_q, pd_d;
    logic [NUM_DIGITS-1:0] shdp_q, shdp_d, pddp_q, pddp_d;
    logic                  pend_q, pend_d;
    logic [7:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_q;

    logic       slot_end, wrap, dead;
    logic [3:0] sel_code;
    logic       sel_dp, sel_lz, lz_run;
    logic [6:0] glyph;

    // ---------------- slot / digit counters ----------------
    assign slot_end = (cnt_q == CNT_LAST);
    assign wrap     = slot_end && (d_q == D_LAST);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        d_d   = d_q;
        if (slot_end) begin
            cnt_d = '0;
            d_d   = (d_q == D_LAST) ? '0 : d_q + D_W'(1);
        end
    end

    // ---------------- pending / shadow data ----------------
    // Shadow only changes on the frame wrap so a scan never shows mixed data.
    always_comb begin
        sh_d   = sh_q;
        shdp_d = shdp_q;
        pd_d   = pd_q;
        pddp_d = pddp_q;
        pend_d = pend_q;
        if (wrap) begin
            pend_d = 1'b0;
            if (LOAD) begin
                sh_d   = DATA;
                shdp_d = DP;
            end else if (pend_q) begin
                sh_d   = pd_q;
                shdp_d = pddp_q;
            end
        end else if (LOAD) begin
            pd_d   = DATA;
            pddp_d = DP;
            pend_d = 1'b1;
        end
    end

    // ---------------- digit select and leading-zero detect ----------------
    // Walk from the most significant digit down; lz_run stays set while every
    // digit from the top down to i is zero.
    always_comb begin
        sel_code = '0;
        sel_dp   = 1'b0;
        sel_lz   = 1'b0;
        lz_run   = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lz_run = lz_run & (sh_q[4*i +: 4] == 4'h0);
            if (d_q == D_W'(i)) begin
                sel_code = sh_q[4*i +: 4];
                sel_dp   = shdp_q[i];
                sel_lz   = lz_run && (i != 0);
            end
        end
    end

    svn_seg_dec u_dec (
        .code_i   (sel_code),
        .hex_en_i (HEX_EN != 0),
        .glyph_o  (glyph)
    );

    generate
        if (BLANK_CYCLES == 0) begin : g_no_dead
            assign dead = 1'b0;
        end else begin : g_dead
            assign dead = (cnt_q < CNT_W'(BLANK_CYCLES));
        end
    endgenerate

    // ---------------- output stage ----------------
    always_comb begin
        seg_d             = SEG_BLANK;
        seg_d[SEG_A:SEG_G] = glyph;
        seg_d[SEG_DP]     = ~sel_dp;
        if (LZ_BLANK && sel_lz)
            seg_d = SEG_BLANK;
        for (int i = 0; i < NUM_DIGITS; i++)
            an_d[i] = (!dead && (d_q == D_W'(i))) ? AN_ON : ~AN_ON;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q   <= '0;
            d_q     <= '0;
            sh_q    <= '0;
            shdp_q  <= '0;
            pd_q    <= '0;
            pddp_q  <= '0;
            pend_q  <= 1'b0;
            seg_q   <= SEG_BLANK;
            an_q    <= {NUM_DIGITS{~AN_ON}};
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            sh_q    <= sh_d;
            shdp_q  <= shdp_d;
            pd_q    <= pd_d;
            pddp_q  <= pddp_d;
            pend_q  <= pend_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            frame_q <= wrap;
        end
    end

    assign SEG   = seg_q;
    assign AN    = an_q;
    assign FRAME = frame_q;

endmodule

// File: tb/tb_svn_seg_mux.sv
// Bench for svn_seg_mux: three configurations driven by shared stimulus and checked
// every cycle against a slot/frame-level model, plus literal pins from the test plan.
module tb_svn_seg_mux;

    logic        clk = 1'b0;
    logic        rst, load, lzb;
    logic [15:0] data;
    logic [3:0]  dp;
    logic [7:0]  seg0, seg1, seg2;
    logic [3:0]  an0, an1;
    logic [0:0]  an2;
    logic        fr0, fr1, fr2;

    always #5 clk = ~clk;

    svn_seg_mux #(.NUM_DIGITS(4), .CLK_DIV(4), .BLANK_CYCLES(1), .HEX_EN(1), .AN_ACTIVE_LOW(1)) u0 (
        .CLK(clk), .RST(rst), .DATA(data), .DP(dp), .LOAD(load), .LZ_BLANK(lzb),
        .SEG(seg0), .AN(an0), .FRAME(fr0));
    svn_seg_mux #(.NUM_DIGITS(4), .CLK_DIV(4), .BLANK_CYCLES(1), .HEX_EN(0), .AN_ACTIVE_LOW(0)) u1 (
        .CLK(clk), .RST(rst), .DATA(data), .DP(dp), .LOAD(load), .LZ_BLANK(lzb),
        .SEG(seg1), .AN(an1), .FRAME(fr1));
    svn_seg_mux #(.NUM_DIGITS(1), .CLK_DIV(2), .BLANK_CYCLES(0), .HEX_EN(1), .AN_ACTIVE_LOW(1)) u2 (
        .CLK(clk), .RST(rst), .DATA(data[3:0]), .DP(dp[0:0]), .LOAD(load), .LZ_BLANK(lzb),
        .SEG(seg2), .AN(an2), .FRAME(fr2));

    // model configuration and state, one entry per instance
    int cfg_nd[3]  = '{4, 4, 1};
    int cfg_div[3] = '{4, 4, 2};
    int cfg_bc[3]  = '{1, 1, 0};
    bit cfg_hex[3] = '{1'b1, 1'b0, 1'b1};
    bit cfg_low[3] = '{1'b1, 1'b0, 1'b1};

    int          m_t[3];
    logic [15:0] m_sh[3], m_pd[3];
    logic [3:0]  m_shdp[3], m_pddp[3];
    bit          m_pv[3];
    logic [7:0]  e_seg[3];
    logic [3:0]  e_an[3];
    bit          e_fr[3];
    int          e_dig[3], e_pos[3];

    int checks = 0;
    int errors = 0;
    int cyc;

    function automatic logic [6:0] glyph(input logic [3:0] c, input bit hex);
        logic [6:0] tbl [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                 7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
        if (c > 4'd9 && !hex) return 7'h7F;
        return tbl[c];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Advance one instance's model across a clock edge (inputs as sampled at the edge).
    task automatic model_edge(input int k);
        int nd, div, pos, dig;
        bit wrap, blank, on, act;
        logic [15:0] dm, upper;
        logic [3:0] dpm, code;
        logic [6:0] g;
        nd  = cfg_nd[k];
        div = cfg_div[k];
        dm  = (nd == 4) ? data : {12'h0, data[3:0]};
        dpm = (nd == 4) ? dp : {3'b0, dp[0]};
        on  = !cfg_low[k];
        pos = m_t[k] % div;
        dig = (m_t[k] / div) % nd;
        e_dig[k] = dig;
        e_pos[k] = pos;
        if (rst) begin
            e_seg[k] = 8'hFF;
            e_an[k]  = '0;
            for (int i = 0; i < nd; i++) e_an[k][i] = ~on;
            e_fr[k]  = 1'b0;
            m_t[k] = 0; m_sh[k] = '0; m_pd[k] = '0; m_shdp[k] = '0; m_pddp[k] = '0; m_pv[k] = 1'b0;
            return;
        end
        wrap  = (pos == div - 1) && (dig == nd - 1);
        upper = m_sh[k] >> (4 * dig);
        code  = upper[3:0];
        blank = lzb && dig > 0 && upper == 16'h0;
        g     = glyph(code, cfg_hex[k]);
        e_seg[k] = blank ? 8'hFF : {g, ~m_shdp[k][dig]};
        act = (pos >= cfg_bc[k]);
        e_an[k] = '0;
        for (int i = 0; i < nd; i++) e_an[k][i] = (act && i == dig) ? on : ~on;
        e_fr[k] = wrap;
        if (wrap) begin
            if (load) begin m_sh[k] = dm; m_shdp[k] = dpm; end
            else if (m_pv[k]) begin m_sh[k] = m_pd[k]; m_shdp[k] = m_pddp[k]; end
            m_pv[k] = 1'b0;
        end else if (load) begin
            m_pd[k] = dm; m_pddp[k] = dpm; m_pv[k] = 1'b1;
        end
        m_t[k] = (m_t[k] + 1) % (nd * div);
    endtask

    task automatic step();
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_edge(k);
        #1;
        chk("seg0", {24'h0, seg0}, {24'h0, e_seg[0]});
        chk("an0",  {28'h0, an0},  {28'h0, e_an[0]});
        chk("fr0",  {31'h0, fr0},  {31'h0, e_fr[0]});
        chk("seg1", {24'h0, seg1}, {24'h0, e_seg[1]});
        chk("an1",  {28'h0, an1},  {28'h0, e_an[1]});
        chk("fr1",  {31'h0, fr1},  {31'h0, e_fr[1]});
        chk("seg2", {24'h0, seg2}, {24'h0, e_seg[2]});
        chk("an2",  {31'h0, an2},  {31'h0, e_an[2][0]});
        chk("fr2",  {31'h0, fr2},  {31'h0, e_fr[2]});
    endtask

    // Step until instance 0's outputs reflect digit dg at slot position ps.
    task automatic wait_at(input int dg, input int ps);
        for (int n = 0; n < 64; n++) begin
            step();
            if (e_dig[0] == dg && e_pos[0] == ps) return;
        end
        chk("wait_at_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_fr();
        for (int n = 0; n < 64; n++) begin
            step();
            if (fr0) return;
        end
        chk("wait_frame_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; lzb = 1'b0; data = '0; dp = '0;
        for (int k = 0; k < 3; k++) begin
            m_t[k] = 0; m_sh[k] = '0; m_pd[k] = '0; m_shdp[k] = '0; m_pddp[k] = '0; m_pv[k] = 1'b0;
        end

        // reset held three cycles
        for (int n = 0; n < 3; n++) begin
            step();
            chk("rst_seg", {24'h0, seg0}, 32'hFF);
            chk("rst_an",  {28'h0, an0},  32'hF);
            chk("rst_fr",  {31'h0, fr0},  32'h0);
        end

        // first FRAME pulse lands in the 17th cycle after release; ND=1 enable stays on
        rst = 1'b0;
        cyc = 1;
        for (int n = 0; n < 40; n++) begin
            step();
            cyc++;
            if (n < 4) begin
                chk("nd1_an_on", {31'h0, an2}, 32'h0);
                chk("nd1_frame", {31'h0, fr2}, ((n % 2) == 1) ? 32'h1 : 32'h0);
            end
            if (fr0) break;
        end
        chk("first_frame_cycle", cyc, 32'd17);

        // 1234 with dp on digit 1
        data = 16'h1234; dp = 4'b0010; load = 1'b1;
        step();
        load = 1'b0;
        wait_fr();
        wait_at(0, 0); chk("dead0_an", {28'h0, an0}, 32'hF);
        wait_at(0, 1); chk("d0_seg", {24'h0, seg0}, 32'b10011001); chk("d0_an", {28'h0, an0}, 32'b1110);
        wait_at(1, 1); chk("d1_seg", {24'h0, seg0}, 32'b00001100); chk("d1_an", {28'h0, an0}, 32'b1101);
        wait_at(2, 0); chk("dead2_an", {28'h0, an0}, 32'hF);
        wait_at(2, 1); chk("d2_seg", {24'h0, seg0}, 32'b00100101); chk("d2_an", {28'h0, an0}, 32'b1011);
        wait_at(3, 1); chk("d3_an", {28'h0, an0}, 32'b0111); chk("d3_an_hi", {28'h0, an1}, 32'b1000);

        // leading-zero blanking, hex on/off
        data = 16'h00A0; dp = 4'b0000; lzb = 1'b1; load = 1'b1;
        step();
        load = 1'b0;
        wait_fr();
        wait_at(0, 1); chk("lz_d0", {24'h0, seg0}, 32'b00000011);
        wait_at(1, 1); chk("lz_d1_hex", {24'h0, seg0}, 32'b00010001); chk("lz_d1_nohex", {24'h0, seg1}, 32'hFF);
        wait_at(2, 1); chk("lz_d2", {24'h0, seg0}, 32'hFF);
        wait_at(3, 1); chk("lz_d3", {24'h0, seg0}, 32'hFF);

        // last-wins pending, then a load coincident with wrap
        lzb = 1'b0;
        data = 16'h1111; load = 1'b1; step(); load = 1'b0;
        wait_at(1, 2);
        data = 16'h2222; load = 1'b1; step(); load = 1'b0;
        for (int n = 0; n < 20 && m_t[0] != 15; n++) step();
        data = 16'h3333; load = 1'b1; step(); load = 1'b0;
        wait_at(0, 1); chk("wrap_d0", {24'h0, seg0}, 32'b00001101);
        wait_at(3, 1); chk("wrap_d3", {24'h0, seg0}, 32'b00001101);

        // reset during digit 2 with a pending load that must be dropped
        wait_at(2, 2);
        data = 16'h5555; load = 1'b1; step(); load = 1'b0;
        rst = 1'b1; step();
        chk("mid_rst_seg", {24'h0, seg0}, 32'hFF);
        chk("mid_rst_an",  {28'h0, an0},  32'hF);
        chk("mid_rst_fr",  {31'h0, fr0},  32'h0);
        rst = 1'b0;
        wait_at(0, 1); chk("post_rst_d0", {24'h0, seg0}, 32'b00000011);
        wait_at(1, 1); chk("post_rst_d1", {24'h0, seg0}, 32'b00000011);
        wait_fr();
        wait_at(0, 1); chk("pend_dropped", {24'h0, seg0}, 32'b00000011);

        // randomized traffic with digit values biased toward zero
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 4; i++)
                data[4*i +: 4] = ($urandom % 2 == 0) ? 4'h0 : 4'($urandom);
            dp   = 4'($urandom);
            load = ($urandom % 8 == 0);
            if ($urandom % 50 == 0) lzb = ~lzb;
            rst  = ($urandom % 300 == 0);
            step();
        end
        rst = 1'b0; load = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
